// File: rtl/alu_pkt_ctrl_pkg.sv
// Shared types and constants for the UART packet sequencer in front of the
// 32-bit ALU: operation codes, wire opcodes, header geometry and FSM states.
package alu_pkt_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_MUL
   } op_t;

   localparam logic [7:0] OPC_ECHO = 8'hEC;
   localparam logic [7:0] OPC_ADD  = 8'h10;
   localparam logic [7:0] OPC_SUB  = 8'h11;
   localparam logic [7:0] OPC_AND  = 8'h12;
   localparam logic [7:0] OPC_OR   = 8'h13;
   localparam logic [7:0] OPC_XOR  = 8'h14;
   localparam logic [7:0] OPC_MUL  = 8'h15;

   localparam int HDR_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   typedef enum logic [3:0] {
      S_OPC,
      S_RSV,
      S_LENL,
      S_LENH,
      S_DISP,
      S_ECHO,
      S_WORD0,
      S_WORDN,
      S_REQ,
      S_WAIT,
      S_TX,
      S_DRAIN
   } state_t;

   // Unknown opcodes map to OP_ADD so the ALU op port has a defined idle value.
   function automatic op_t opc2op(input logic [7:0] opc);
      case (opc)
         OPC_SUB: return OP_SUB;
         OPC_AND: return OP_AND;
         OPC_OR:  return OP_OR;
         OPC_XOR: return OP_XOR;
         OPC_MUL: return OP_MUL;
         default: return OP_ADD;
      endcase
   endfunction

   function automatic logic is_arith(input logic [7:0] opc);
      return (opc >= OPC_ADD) && (opc <= OPC_MUL);
   endfunction

endpackage

// File: rtl/alu_pkt_beat_shift.sv
// Big-endian byte-to-word shift register with a byte counter; word_done fires
// combinationally on the shift that completes a word.
module alu_pkt_beat_shift
   import alu_pkt_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  din,
   input  logic        load_en,
   input  logic [31:0] load_word,
   output logic [31:0] word,
   output logic        word_done
);

   localparam int CNT_W = $clog2(WORD_BYTES);

   logic [CNT_W-1:0] cnt;

   assign word_done = shift_en && (cnt == CNT_W'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         word <= '0;
      end else begin
         if (clr)
            cnt <= '0;
         else if (shift_en)
            cnt <= cnt + CNT_W'(1);

         if (load_en)
            word <= load_word;
         else if (shift_en)
            word <= {word[23:0], din};
      end
   end

endmodule

// File: rtl/alu_pkt_ctrl.sv
// Packet sequencer between the UART byte streams and the 32-bit ALU: parses a
// 4-byte header, then echoes the payload or folds payload words through the ALU.
module alu_pkt_ctrl
   import alu_pkt_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output op_t         alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic        alu_valid_o,
   input  logic        alu_ready_i,
   input  logic [31:0] alu_res_i,
   input  logic        alu_res_valid_i,
   output logic        err_o
);

   state_t      state;
   state_t      state_nxt;
   logic        active;
   logic [7:0]  opc_r;
   logic [15:0] len_r;
   logic [15:0] cnt_r;
   logic [13:0] words_left;
   logic [31:0] tmo_cnt;
   logic        err_nxt;

   logic        s_hs;
   logic        m_hs;
   logic        timed;
   logic        tmo_hit;

   logic        sh_clr;
   logic        acc_shift;
   logic        acc_load;
   logic        acc_done;
   logic [7:0]  acc_din;
   logic [31:0] acc;
   logic        b_shift;
   logic        b_done;
   logic [31:0] opb;

   assign s_hs  = s_axis_tvalid & s_axis_tready;
   assign m_hs  = m_axis_tvalid & m_axis_tready;
   assign timed = state inside {S_RSV, S_LENL, S_LENH, S_ECHO, S_WORD0, S_WORDN, S_DRAIN};

   assign tmo_hit = (TIMEOUT_CYCLES != 0) && timed && !s_hs &&
                    (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   assign alu_valid_o = (state == S_REQ);
   assign alu_a_o     = alu_valid_o ? acc : '0;
   assign alu_b_o     = alu_valid_o ? opb : '0;
   assign alu_op_o    = opc2op(opc_r);

   // During transmit the accumulator shifts out MSB first, back-filling zeros.
   assign acc_din = (state == S_TX) ? 8'h00 : s_axis_tdata;

   alu_pkt_beat_shift u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (sh_clr),
      .shift_en  (acc_shift),
      .din       (acc_din),
      .load_en   (acc_load),
      .load_word (alu_res_i),
      .word      (acc),
      .word_done (acc_done)
   );

   alu_pkt_beat_shift u_opb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (sh_clr),
      .shift_en  (b_shift),
      .din       (s_axis_tdata),
      .load_en   (1'b0),
      .load_word (32'h0),
      .word      (opb),
      .word_done (b_done)
   );

   // Stream handshakes depend only on the state and the opposite stream.
   always_comb begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      case (state)
         S_OPC:   s_axis_tready = active;
         S_RSV, S_LENL, S_LENH, S_WORD0, S_WORDN, S_DRAIN:
                  s_axis_tready = 1'b1;
         S_ECHO: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
         end
         S_TX: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = acc[31:24];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      sh_clr    = 1'b0;
      acc_shift = 1'b0;
      acc_load  = 1'b0;
      b_shift   = 1'b0;
      case (state)
         S_OPC:  if (s_hs) state_nxt = S_RSV;
         S_RSV:  if (s_hs) state_nxt = S_LENL;
         S_LENL: if (s_hs) state_nxt = S_LENH;
         S_LENH: if (s_hs) state_nxt = S_DISP;
         S_DISP: begin
            sh_clr = 1'b1;
            if (len_r < 16'(HDR_BYTES)) begin
               err_nxt   = 1'b1;
               state_nxt = S_OPC;
            end else if (opc_r == OPC_ECHO) begin
               state_nxt = (len_r == 16'(HDR_BYTES)) ? S_OPC : S_ECHO;
            end else if (is_arith(opc_r) && (len_r >= 16'd8) && (len_r[1:0] == 2'b00)) begin
               state_nxt = S_WORD0;
            end else begin
               // A bad packet with no payload has nothing to drain.
               err_nxt   = 1'b1;
               state_nxt = (len_r == 16'(HDR_BYTES)) ? S_OPC : S_DRAIN;
            end
         end
         S_ECHO, S_DRAIN: begin
            if (s_hs && (cnt_r == 16'd1))
               state_nxt = S_OPC;
         end
         S_WORD0: begin
            acc_shift = s_hs;
            if (acc_done)
               state_nxt = (words_left == '0) ? S_TX : S_WORDN;
         end
         S_WORDN: begin
            b_shift = s_hs;
            if (b_done)
               state_nxt = S_REQ;
         end
         S_REQ: if (alu_ready_i) state_nxt = S_WAIT;
         S_WAIT: begin
            if (alu_res_valid_i) begin
               acc_load  = 1'b1;
               state_nxt = (words_left == 14'd1) ? S_TX : S_WORDN;
            end
         end
         S_TX: begin
            acc_shift = m_hs;
            if (acc_done)
               state_nxt = S_OPC;
         end
         default: state_nxt = S_OPC;
      endcase

      // An inter-byte stall aborts the packet from any byte-consuming state.
      if (tmo_hit) begin
         state_nxt = S_OPC;
         err_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_OPC;
         active     <= 1'b0;
         err_o      <= 1'b0;
         opc_r      <= '0;
         len_r      <= '0;
         cnt_r      <= '0;
         words_left <= '0;
         tmo_cnt    <= '0;
      end else begin
         state  <= state_nxt;
         active <= 1'b1;
         err_o  <= err_nxt;

         if (!timed || s_hs || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 32'd1;

         case (state)
            S_OPC:  if (s_hs) opc_r <= s_axis_tdata;
            S_LENL: if (s_hs) len_r[7:0] <= s_axis_tdata;
            S_LENH: if (s_hs) len_r[15:8] <= s_axis_tdata;
            S_DISP: begin
               cnt_r      <= len_r - 16'(HDR_BYTES);
               words_left <= 14'((len_r - 16'(HDR_BYTES)) >> 2) - 14'd1;
            end
            S_ECHO, S_DRAIN: if (s_hs) cnt_r <= cnt_r - 16'd1;
            S_WAIT: if (alu_res_valid_i) words_left <= words_left - 14'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
// Directed bench for alu_pkt_ctrl: echo, ADD/MUL folding with ALU stalls,
// malformed packets, inter-byte timeout and asynchronous reset during transmit.
module tb_alu_pkt_ctrl;
   import alu_pkt_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   op_t         alu_op_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic        alu_valid_o;
   logic        alu_ready_i;
   logic [31:0] alu_res_i;
   logic        alu_res_valid_i;
   logic        err_o;

   int total   = 0;
   int bad     = 0;
   int err_cnt = 0;
   int req_cnt = 0;
   logic [7:0] tx_q[$];

   always #5 clk = ~clk;

   alu_pkt_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .alu_op_o        (alu_op_o),
      .alu_a_o         (alu_a_o),
      .alu_b_o         (alu_b_o),
      .alu_valid_o     (alu_valid_o),
      .alu_ready_i     (alu_ready_i),
      .alu_res_i       (alu_res_i),
      .alu_res_valid_i (alu_res_valid_i),
      .err_o           (err_o)
   );

   always @(posedge clk) begin
      if (m_axis_tvalid && m_axis_tready) tx_q.push_back(m_axis_tdata);
      if (err_o) err_cnt++;
      if (alu_valid_o && alu_ready_i) req_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      @(negedge clk);
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      #1;
      while (!s_axis_tready && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (k >= 300) chk("send_byte_ready", s_axis_tready, 1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] opc, input logic [15:0] len);
      send_byte(opc);
      send_byte(8'h00);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   // Waits for n transmitted bytes, then checks count and content MSB first.
   task automatic chk_tx(input string tag, input int n, input logic [31:0] exp);
      int k = 0;
      logic [31:0] o;
      while (tx_q.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_cnt"}, tx_q.size(), n);
      for (int i = 0; i < n; i++) begin
         o = (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF;
         chk(tag, o, {24'h0, exp[8*(n-1-i) +: 8]});
      end
      tx_q.delete();
   endtask

   task automatic wait_tvalid(input string tag);
      int k = 0;
      while (!m_axis_tvalid && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_tvalid"}, m_axis_tvalid, 1);
   endtask

   task automatic alu_serve(input string tag, input int stall, input logic [31:0] ea,
                            input logic [31:0] eb, input op_t eop, input logic [31:0] res);
      int k = 0;
      @(negedge clk);
      while (!alu_valid_o && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_valid"}, alu_valid_o, 1);
      chk({tag, "_a"}, alu_a_o, ea);
      chk({tag, "_b"}, alu_b_o, eb);
      chk({tag, "_op"}, 32'(alu_op_o), 32'(eop));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_hold_v"}, alu_valid_o, 1);
         chk({tag, "_hold_a"}, alu_a_o, ea);
         chk({tag, "_hold_b"}, alu_b_o, eb);
      end
      alu_ready_i = 1'b1;
      @(posedge clk);
      #1;
      alu_ready_i = 1'b0;
      chk({tag, "_drop"}, alu_valid_o, 0);
      @(negedge clk);
      alu_res_i       = res;
      alu_res_valid_i = 1'b1;
      @(posedge clk);
      #1;
      alu_res_valid_i = 1'b0;
      alu_res_i       = '0;
   endtask

   initial begin
      rst_n           = 1'b0;
      s_axis_tdata    = '0;
      s_axis_tvalid   = 1'b0;
      m_axis_tready   = 1'b1;
      alu_ready_i     = 1'b0;
      alu_res_i       = '0;
      alu_res_valid_i = 1'b0;
      #1;
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_alu_valid", alu_valid_o, 0);
      chk("rst_alu_a", alu_a_o, 0);
      chk("rst_alu_b", alu_b_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_alu_op", 32'(alu_op_o), 32'(OP_ADD));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_s_tready", s_axis_tready, 1);

      // echo 'A','B','C'
      send_hdr(OPC_ECHO, 16'd7);
      send_byte(8'h41);
      send_byte(8'h42);
      send_byte(8'h43);
      chk_tx("echo_tx", 3, 32'h0041_4243);
      chk("echo_err", err_cnt, 0);
      chk("echo_idle", s_axis_tready, 1);

      // ADD 5 + FFFFFFFE, transmit with uart_tx backpressure
      m_axis_tready = 1'b0;
      send_hdr(OPC_ADD, 16'h000C);
      send_word(32'h0000_0005);
      send_word(32'hFFFF_FFFE);
      alu_serve("add", 0, 32'h0000_0005, 32'hFFFF_FFFE, OP_ADD, 32'h0000_0003);
      wait_tvalid("add_tx");
      chk("add_b0_data", m_axis_tdata, 8'h00);
      repeat (3) begin
         @(negedge clk);
         m_axis_tready = 1'b1;
         @(posedge clk);
         #1;
         m_axis_tready = 1'b0;
      end
      repeat (2) begin
         @(negedge clk);
         chk("add_hold_valid", m_axis_tvalid, 1);
         chk("add_hold_data", m_axis_tdata, 8'h03);
      end
      m_axis_tready = 1'b1;
      chk_tx("add_tx", 4, 32'h0000_0003);
      chk("add_req_cnt", req_cnt, 1);

      // MUL 3*4*0x80000000 with a 5-cycle ALU stall on the first request
      send_hdr(OPC_MUL, 16'h0010);
      send_word(32'h0000_0003);
      send_word(32'h0000_0004);
      alu_serve("mul1", 5, 32'h0000_0003, 32'h0000_0004, OP_MUL, 32'h0000_000C);
      send_word(32'h8000_0000);
      alu_serve("mul2", 0, 32'h0000_000C, 32'h8000_0000, OP_MUL, 32'h0000_0000);
      chk_tx("mul_tx", 4, 32'h0000_0000);
      chk("mul_req_cnt", req_cnt, 3);
      chk("mul_err", err_cnt, 0);

      // unknown opcode: drained with one error, then echo recovers
      send_hdr(8'h7F, 16'd6);
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk_tx("badop_tx", 0, 32'h0);
      chk("badop_err", err_cnt, 1);
      send_hdr(OPC_ECHO, 16'd5);
      send_byte(8'h5A);
      chk_tx("echo2_tx", 1, 32'h0000_005A);

      // ADD with LEN=10: six bytes drained, no ALU request
      send_hdr(OPC_ADD, 16'h000A);
      send_word(32'h0102_0304);
      send_byte(8'h05);
      send_byte(8'h06);
      chk_tx("drain_tx", 0, 32'h0);
      chk("drain_err", err_cnt, 2);
      chk("drain_req_cnt", req_cnt, 3);
      send_hdr(OPC_ECHO, 16'd5);
      send_byte(8'h51);
      chk_tx("echo3_tx", 1, 32'h0000_0051);

      // stall after the 2nd echo payload byte until the timeout fires
      send_hdr(OPC_ECHO, 16'd8);
      send_byte(8'h61);
      send_byte(8'h62);
      repeat (95) @(negedge clk);
      chk("tmo_not_early", err_cnt, 2);
      repeat (10) @(negedge clk);
      chk("tmo_err", err_cnt, 3);
      chk_tx("tmo_tx", 2, 32'h0000_6162);
      send_hdr(OPC_ECHO, 16'd5);
      send_byte(8'h54);
      chk_tx("echo4_tx", 1, 32'h0000_0054);

      // single-word ADD goes straight to transmit; reset hits mid-transmit
      m_axis_tready = 1'b0;
      send_hdr(OPC_ADD, 16'd8);
      send_word(32'h1122_3344);
      wait_tvalid("rtx");
      chk("rtx_b0_data", m_axis_tdata, 8'h11);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rtx_rst_tvalid", m_axis_tvalid, 0);
      chk("rtx_rst_tdata", m_axis_tdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_axis_tready = 1'b1;
      chk_tx("rtx_tx", 0, 32'h0);
      chk("rtx_err", err_cnt, 3);
      chk("rtx_req_cnt", req_cnt, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
